// File: rtl/instr_fetch_queue.sv
// instr_fetch_queue: in-order instruction fetch with credit-limited request issue, PC-tagged response queue and redirect flush
module instr_fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic                       clock,
  input  logic                       reset,
  output logic                       imem_req_valid,
  input  logic                       imem_req_ready,
  output logic [31:0]                imem_req_addr,
  input  logic                       imem_resp_valid,
  input  logic [31:0]                imem_resp_data,
  input  logic                       redirect_valid,
  input  logic [31:0]                redirect_pc,
  output logic                       inst_valid,
  input  logic                       inst_ready,
  output logic [31:0]                inst_data,
  output logic [31:0]                inst_pc,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
);
  localparam int W = $clog2(DEPTH+1);
  localparam int P = $clog2(DEPTH);
  logic [31:0]  fetch_pc, resp_pc, target;
  logic [W-1:0] inflight, drop_cnt, count, inflight_after;
  logic [P-1:0] rd_ptr, wr_ptr;
  logic [31:0]  inst_mem [DEPTH];
  logic [31:0]  pc_mem [DEPTH];
  logic         req_fire, resp_fire, push, pop;
  always_comb begin
    imem_req_valid = !reset && !redirect_valid && (({1'b0, count} + {1'b0, inflight}) < (W+1)'(DEPTH));
    imem_req_addr  = fetch_pc;
    req_fire       = imem_req_valid && imem_req_ready;
    resp_fire      = imem_resp_valid && inflight != '0;
    push           = resp_fire && drop_cnt == '0 && !redirect_valid;
    inst_valid     = count != '0;
    pop            = inst_valid && inst_ready && !redirect_valid;
    inflight_after = inflight + W'(req_fire) - W'(resp_fire);
    inst_data      = inst_valid ? inst_mem[rd_ptr] : 32'h0000_0013;
    inst_pc        = inst_valid ? pc_mem[rd_ptr] : 32'h0;
    occupancy      = count;
    target         = redirect_pc & ~32'h3;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      fetch_pc <= RESET_PC;
      resp_pc  <= RESET_PC;
      inflight <= '0;
      drop_cnt <= '0;
      count    <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
    end else begin
      inflight <= inflight_after;
      if (redirect_valid) begin
        fetch_pc <= target;
        resp_pc  <= target;
        drop_cnt <= inflight_after;
        count    <= '0;
        rd_ptr   <= '0;
        wr_ptr   <= '0;
      end else begin
        if (req_fire) fetch_pc <= fetch_pc + 32'd4;
        if (resp_fire && drop_cnt != '0) drop_cnt <= drop_cnt - W'(1);
        if (push) resp_pc <= resp_pc + 32'd4;
        if (push) wr_ptr <= wr_ptr + P'(1);
        if (pop) rd_ptr <= rd_ptr + P'(1);
        count <= count + W'(push) - W'(pop);
      end
    end
  end
  always_ff @(posedge clock) begin
    if (push) begin
      inst_mem[wr_ptr] <= imem_resp_data;
      pc_mem[wr_ptr]   <= resp_pc;
    end
  end
endmodule

// File: tb/tb_instr_fetch_queue.sv
// tb_instr_fetch_queue: phase table plus redirect/reset sequences against a latency memory model and PC scoreboard
module tb_instr_fetch_queue;
  logic        clock = 1'b0, reset = 1'b1;
  logic        imem_req_valid, imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid = 1'b0;
  logic [31:0] imem_resp_data = 32'h0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        inst_valid, inst_ready = 1'b0;
  logic [31:0] inst_data, inst_pc;
  logic [2:0]  occupancy;
  instr_fetch_queue #(.DEPTH(4), .RESET_PC(32'h0)) dut (
    .clock(clock), .reset(reset),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_data(inst_data), .inst_pc(inst_pc),
    .occupancy(occupancy)
  );
  always #5 clock = ~clock;
  typedef struct {logic [31:0] pc; logic [31:0] data;} ent_t;
  typedef struct {logic [31:0] addr; logic [31:0] data; int due;} mreq_t;
  typedef struct {int n; logic ird; logic rqr; int occ; logic iv; logic rv; int infl; int pops; logic hold;} vec_t;
  ent_t        sb[$];
  mreq_t       mq[$];
  vec_t        vt[5];
  int          vectors = 0, miscompares = 0, cyc = 0, lat = 1, pops = 0;
  logic [31:0] mxor = 32'h0;
  logic        snap_rv, snap_rsp, acc;
  logic [31:0] snap_addr;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic tick(input logic ird, input logic rqr, input logic redir, input logic [31:0] rpc);
    inst_ready      = ird;
    imem_req_ready  = rqr;
    redirect_valid  = redir;
    redirect_pc     = rpc;
    imem_resp_valid = mq.size() != 0 && mq[0].due <= cyc;
    imem_resp_data  = imem_resp_valid ? mq[0].data : 32'h0;
    #1;
    chk("credit", (32'(occupancy) + 32'(mq.size())) <= 4 ? 32'd1 : 32'd0, 32'd1);
    snap_rv   = imem_req_valid;
    snap_addr = imem_req_addr;
    snap_rsp  = imem_resp_valid;
    acc       = snap_rv && rqr;
    if (inst_valid && ird && !redir && !reset) begin
      pops++;
      chk("pop_expected", sb.size() != 0 ? 32'd1 : 32'd0, 32'd1);
      if (sb.size() != 0) begin
        chk("pop_pc", inst_pc, sb[0].pc);
        chk("pop_data", inst_data, sb[0].data);
        void'(sb.pop_front());
      end
    end
    if (snap_rsp) void'(mq.pop_front());
    if (acc) begin
      mq.push_back('{snap_addr, snap_addr ^ mxor, cyc + lat});
      if (!redir) sb.push_back('{snap_addr, snap_addr ^ mxor});
    end
    if (redir) sb.delete();
    if (reset) begin
      sb.delete();
      mq.delete();
    end
    @(posedge clock);
    cyc++;
    @(negedge clock);
  endtask
  task automatic do_reset();
    reset = 1'b1;
    tick(1'b0, 1'b1, 1'b0, 32'h0);
    tick(1'b0, 1'b1, 1'b0, 32'h0);
    chk("rst_req_valid", imem_req_valid, 32'd0);
    chk("rst_inst_valid", inst_valid, 32'd0);
    chk("rst_inst_data", inst_data, 32'h13);
    chk("rst_inst_pc", inst_pc, 32'h0);
    chk("rst_occupancy", occupancy, 32'd0);
    reset = 1'b0;
  endtask
  task automatic drain();
    for (int i = 0; i < 16; i++) tick(1'b1, 1'b0, 1'b0, 32'h0);
    chk("drain_sb_empty", sb.size(), 32'd0);
    chk("drain_occupancy", occupancy, 32'd0);
  endtask
  task automatic wait_valid(input string name);
    for (int i = 0; i < 20 && !inst_valid; i++) tick(1'b0, 1'b1, 1'b0, 32'h0);
    chk(name, inst_valid, 32'd1);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
  initial begin
    logic [31:0] start_addr;
    vt[0] = '{20, 1'b1, 1'b1, 1, 1'b1, 1'b1, 1, 18, 1'b0};
    vt[1] = '{10, 1'b0, 1'b1, 4, 1'b1, 1'b0, 0, 0, 1'b0};
    vt[2] = '{12, 1'b1, 1'b1, 2, 1'b1, 1'b1, 1, 12, 1'b0};
    vt[3] = '{5, 1'b1, 1'b0, 0, 1'b0, 1'b1, 0, 3, 1'b1};
    vt[4] = '{6, 1'b1, 1'b1, 1, 1'b1, 1'b1, 1, 4, 1'b0};
    @(negedge clock);
    do_reset();
    for (int v = 0; v < 5; v++) begin
      pops = 0;
      start_addr = imem_req_addr;
      for (int c = 0; c < vt[v].n; c++) tick(vt[v].ird, vt[v].rqr, 1'b0, 32'h0);
      chk($sformatf("ph%0d_occ", v), occupancy, vt[v].occ);
      chk($sformatf("ph%0d_inst_valid", v), inst_valid, vt[v].iv);
      chk($sformatf("ph%0d_req_valid", v), imem_req_valid, vt[v].rv);
      chk($sformatf("ph%0d_inflight", v), mq.size(), vt[v].infl);
      chk($sformatf("ph%0d_pops", v), pops, vt[v].pops);
      if (vt[v].hold) chk($sformatf("ph%0d_addr_hold", v), imem_req_addr, start_addr);
    end
    drain();
    do_reset();
    lat = 3;
    mxor = 32'hA5A5_0000;
    tick(1'b0, 1'b1, 1'b0, 32'h0);
    tick(1'b0, 1'b1, 1'b0, 32'h0);
    tick(1'b0, 1'b1, 1'b1, 32'h103);
    chk("rdr_no_req", snap_rv, 32'd0);
    tick(1'b0, 1'b1, 1'b0, 32'h0);
    chk("rdr_first_req", snap_rv, 32'd1);
    chk("rdr_first_addr", snap_addr, 32'h100);
    wait_valid("rdr_head_valid");
    chk("rdr_head_pc", inst_pc, 32'h100);
    chk("rdr_head_data", inst_data, 32'h100 ^ mxor);
    drain();
    do_reset();
    lat = 1;
    for (int i = 0; i < 4; i++) tick(1'b0, 1'b1, 1'b0, 32'h0);
    chk("rp_setup_occ", occupancy, 32'd3);
    tick(1'b1, 1'b1, 1'b1, 32'h200);
    chk("rp_resp_same_cycle", snap_rsp, 32'd1);
    chk("rp_no_req", snap_rv, 32'd0);
    chk("rp_occ", occupancy, 32'd0);
    chk("rp_inst_valid", inst_valid, 32'd0);
    chk("rp_inst_data", inst_data, 32'h13);
    chk("rp_inst_pc", inst_pc, 32'h0);
    wait_valid("rp_head_valid");
    chk("rp_head_pc", inst_pc, 32'h200);
    drain();
    do_reset();
    lat = 3;
    for (int i = 0; i < 5; i++) tick(1'b0, 1'b1, 1'b0, 32'h0);
    chk("mr_setup_occ", occupancy, 32'd2);
    reset = 1'b1;
    tick(1'b0, 1'b1, 1'b0, 32'h0);
    chk("mr_req_valid", snap_rv, 32'd0);
    chk("mr_occ", occupancy, 32'd0);
    chk("mr_inst_valid", inst_valid, 32'd0);
    chk("mr_inst_data", inst_data, 32'h13);
    chk("mr_inst_pc", inst_pc, 32'h0);
    reset = 1'b0;
    tick(1'b1, 1'b1, 1'b0, 32'h0);
    chk("mr_first_req", snap_rv, 32'd1);
    chk("mr_first_addr", snap_addr, 32'h0);
    wait_valid("mr_head_valid");
    chk("mr_head_pc", inst_pc, 32'h0);
    drain();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
